// File: rtl/scr1_tb_trace_pkg.sv
// Shared types for the retire-trace collector: record layout, store-size encoding, timestamp width.
package scr1_tb_trace_pkg;

    localparam int SCR1_TRACE_TS_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HWORD = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_ERR   = 2'd3
    } type_scr1_trace_size_e;

    typedef struct packed {
        logic [SCR1_TRACE_TS_W-1:0] ts;
        logic [31:0]                seq;
        logic [31:0]                pc;
        logic                       rd_v;
        logic [4:0]                 rd_addr;
        logic [31:0]                rd_data;
        logic                       ld_v;
        logic                       st_v;
        type_scr1_trace_size_e      size;
        logic [31:0]                mem_addr;
        logic [31:0]                mem_data;
    } type_scr1_trace_rec_s;

    // One-hot {word, hword, byte}; anything multi-hot maps to SIZE_ERR.
    function automatic type_scr1_trace_size_e wen_to_size(input logic [2:0] wen);
        case (wen)
            3'b000:  return SIZE_BYTE;
            3'b001:  return SIZE_BYTE;
            3'b010:  return SIZE_HWORD;
            3'b100:  return SIZE_WORD;
            default: return SIZE_ERR;
        endcase
    endfunction

endpackage

// File: rtl/scr1_tb_trace_fifo.sv
// Generic show-ahead synchronous FIFO; head visible one cycle after push into an empty FIFO.
// Caller qualifies push/pop; full/empty come from the occupancy count, head reads 0 when empty.
module scr1_tb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; stale entries are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/scr1_tb_trace_collector.sv
// Packs per-cycle commit probes into timestamped records (optional LSU probes via SCR1_TRACE_MEM_EN).
// Latency: event at cycle N appears on out_rec_o at N+1 when empty; valid/ready drain, drops counted when full.
module scr1_tb_trace_collector
    import scr1_tb_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en_i,
    input  logic [4:0]                rd_addr_i,
    input  logic [31:0]               rd_wdata_i,
    input  logic [31:0]               pc_i,
    input  logic                      mem_ren_i,
    input  logic [2:0]                mem_wen_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               mem_wdata_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output type_scr1_trace_rec_s      out_rec_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      overflow_o,
    output logic                      wen_err_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);
    localparam int                REC_W    = $bits(type_scr1_trace_rec_s);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    type_scr1_trace_rec_s       rec;
    logic                       evt;
    logic                       wen_multi;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic [REC_W-1:0]           fifo_rdata;
    logic [SCR1_TRACE_TS_W-1:0] ts;
    logic [31:0]                seq;

    always_comb begin
        rec       = '0;
        evt       = 1'b0;
        wen_multi = 1'b0;
        rec.ts    = ts;
        rec.seq   = seq;
        rec.pc    = pc_i;
        rec.rd_v  = rd_en_i;
        if (rd_en_i) begin
            rec.rd_addr = rd_addr_i;
            rec.rd_data = rd_wdata_i;
        end
`ifdef SCR1_TRACE_MEM_EN
        rec.ld_v = mem_ren_i;
        rec.st_v = |mem_wen_i;
        if (rec.st_v) begin
            rec.size     = wen_to_size(mem_wen_i);
            rec.mem_data = mem_wdata_i;
        end
        if (rec.ld_v | rec.st_v) begin
            rec.mem_addr = mem_addr_i;
        end
        wen_multi = rec.st_v & (rec.size == SIZE_ERR);
        evt       = rd_en_i | mem_ren_i | rec.st_v;
`else
        evt       = rd_en_i;
`endif
    end

`ifndef SCR1_TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{mem_ren_i, mem_wen_i, mem_addr_i, mem_wdata_i};
`endif

    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign pop         = out_valid_o & out_ready_i;
    assign push        = evt & (~full | pop);
    assign out_valid_o = ~empty;
    assign out_rec_o   = type_scr1_trace_rec_s'(fifo_rdata);

    scr1_tb_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rec),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts         <= '0;
            seq        <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
            wen_err_o  <= 1'b0;
        end else begin
            ts <= ts + 32'd1;
            if (push) begin
                seq <= seq + 32'd1;
            end
            if (evt & ~push) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != DROP_MAX) begin
                    drop_cnt_o <= drop_cnt_o + DROP_ONE;
                end
            end
            if (wen_multi) begin
                wen_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scr1_tb_trace_collector.sv
// Directed bench with a record scoreboard for scr1_tb_trace_collector (honours SCR1_TRACE_MEM_EN).
module tb_scr1_tb_trace_collector;
    import scr1_tb_trace_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     rd_en;
    logic [4:0]               rd_addr;
    logic [31:0]              rd_wdata;
    logic [31:0]              pc;
    logic                     mem_ren;
    logic [2:0]               mem_wen;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic                     out_valid;
    logic                     out_ready;
    type_scr1_trace_rec_s     out_rec;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     wen_err;
    logic [DROP_W-1:0]        drop_cnt;

    type_scr1_trace_rec_s     sb[$];
    int unsigned              mts, mseq, mdrop;
    logic                     movf, mwerr;
    int                       total = 0;
    int                       bad = 0;

    always #5 clk = ~clk;

    scr1_tb_trace_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_wdata_i  (rd_wdata),
        .pc_i        (pc),
        .mem_ren_i   (mem_ren),
        .mem_wen_i   (mem_wen),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_rec_o   (out_rec),
        .level_o     (level),
        .overflow_o  (overflow),
        .wen_err_o   (wen_err),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    function automatic logic multi_hot(input logic [2:0] w);
        return (w != 3'b000) && (w != 3'b001) && (w != 3'b010) && (w != 3'b100);
    endfunction

    function automatic type_scr1_trace_rec_s mk_rec();
        type_scr1_trace_rec_s r;
        r      = '0;
        r.ts   = mts;
        r.seq  = mseq;
        r.pc   = pc;
        r.rd_v = rd_en;
        if (rd_en) begin
            r.rd_addr = rd_addr;
            r.rd_data = rd_wdata;
        end
`ifdef SCR1_TRACE_MEM_EN
        r.ld_v = mem_ren;
        r.st_v = (mem_wen != 3'b000);
        if (r.st_v) begin
            r.mem_data = mem_wdata;
            case (mem_wen)
                3'b001:  r.size = SIZE_BYTE;
                3'b010:  r.size = SIZE_HWORD;
                3'b100:  r.size = SIZE_WORD;
                default: r.size = SIZE_ERR;
            endcase
        end
        if (r.ld_v || r.st_v) r.mem_addr = mem_addr;
`endif
        return r;
    endfunction

    // Check visible state against the model, then clock one cycle with current inputs.
    task automatic cyc();
        type_scr1_trace_rec_s exp_rec;
        logic evt, pop_m, push_m, werr_m;
        chk("level", 256'(level), 256'(sb.size()));
        chk("valid", 256'(out_valid), 256'(sb.size() != 0));
        if (sb.size() != 0) chk("head", 256'(out_rec), 256'(sb[0]));
        else                chk("empty_rec", 256'(out_rec), 256'(0));
        chk("drop_cnt", 256'(drop_cnt), 256'(mdrop));
        chk("overflow", 256'(overflow), 256'(movf));
        chk("wen_err", 256'(wen_err), 256'(mwerr));
        exp_rec = mk_rec();
`ifdef SCR1_TRACE_MEM_EN
        evt    = rd_en || mem_ren || (mem_wen != 3'b000);
        werr_m = multi_hot(mem_wen);
`else
        evt    = rd_en;
        werr_m = 1'b0;
`endif
        pop_m  = (sb.size() != 0) && out_ready;
        push_m = evt && ((sb.size() < DEPTH) || pop_m);
        @(posedge clk);
        #1;
        if (pop_m) void'(sb.pop_front());
        if (push_m) begin
            sb.push_back(exp_rec);
            mseq++;
        end else if (evt) begin
            movf = 1'b1;
            if (mdrop != 32'hFFFF) mdrop++;
        end
        if (werr_m) mwerr = 1'b1;
        mts++;
    endtask

    task automatic idle_in();
        rd_en = 1'b0; rd_addr = '0; rd_wdata = '0; pc = '0;
        mem_ren = 1'b0; mem_wen = 3'b000; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        mts = 0; mseq = 0; mdrop = 0; movf = 1'b0; mwerr = 1'b0;
    endtask

    initial begin
        type_scr1_trace_rec_s r;
        out_ready = 1'b1;
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First record: event at cycle 3, visible at cycle 4 with ts=3, seq=0.
        repeat (3) cyc();
        rd_en = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEADBEEF; pc = 32'h200;
        cyc();
        idle_in();
        r = '0; r.ts = 32'd3; r.seq = 32'd0; r.pc = 32'h200;
        r.rd_v = 1'b1; r.rd_addr = 5'd5; r.rd_data = 32'hDEADBEEF;
        chk("first_valid", 256'(out_valid), 256'(1));
        chk("first_rec", 256'(out_rec), 256'(r));
        cyc();

        // Word store, then load+store and load-only.
        pc = 32'h204; mem_wen = 3'b100; mem_addr = 32'h1000; mem_wdata = 32'h12345678;
        cyc();
        idle_in();
`ifdef SCR1_TRACE_MEM_EN
        chk("store_st_v", 256'(out_rec.st_v), 256'(1));
        chk("store_size", 256'(out_rec.size), 256'(2));
`else
        chk("store_ignored_level", 256'(level), 256'(0));
        chk("store_ignored_valid", 256'(out_valid), 256'(0));
`endif
        pc = 32'h208; mem_ren = 1'b1; mem_wen = 3'b010; mem_addr = 32'h2002; mem_wdata = 32'hCAFE0001;
        cyc();
        pc = 32'h20C; mem_wen = 3'b000; mem_addr = 32'h3000;
        cyc();
        idle_in();
        repeat (3) cyc();

        // Overflow: 20 events into a stalled 16-entry FIFO.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i); rd_wdata = $urandom; pc = 32'h400 + 32'(4 * i);
            cyc();
        end
        idle_in();
        chk("ovf_level", 256'(level), 256'(16));
        chk("ovf_drop", 256'(drop_cnt), 256'(4));
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_head_seq", 256'(out_rec.seq), 256'(0));

        // Full with simultaneous push and pop: push is accepted.
        out_ready = 1'b1;
        rd_en = 1'b1; rd_addr = 5'd31; rd_wdata = 32'hA5A5A5A5; pc = 32'h500;
        cyc();
        idle_in();
        chk("fullpp_level", 256'(level), 256'(16));
        chk("fullpp_drop", 256'(drop_cnt), 256'(4));

        // Stream with ready toggling every other cycle.
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 2 == 0);
            rd_en = (i % 3 != 0); rd_addr = 5'(i); rd_wdata = $urandom; pc = 32'h600 + 32'(4 * i);
            cyc();
        end
        idle_in();
        out_ready = 1'b1;
        repeat (20) cyc();
        chk("drained_level", 256'(level), 256'(0));

        // Multi-hot store width.
        pc = 32'h700; mem_wen = 3'b011; mem_addr = 32'h4000; mem_wdata = 32'h55AA55AA;
        cyc();
        idle_in();
`ifdef SCR1_TRACE_MEM_EN
        chk("werr_size", 256'(out_rec.size), 256'(3));
        chk("werr_flag", 256'(wen_err), 256'(1));
`else
        chk("werr_flag_off", 256'(wen_err), 256'(0));
`endif
        repeat (3) cyc();
`ifdef SCR1_TRACE_MEM_EN
        chk("werr_sticky", 256'(wen_err), 256'(1));
`else
        chk("werr_sticky_off", 256'(wen_err), 256'(0));
`endif

        // Reset with seven buffered records.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i + 1); rd_wdata = 32'h100 + 32'(i); pc = 32'h800 + 32'(4 * i);
            cyc();
        end
        idle_in();
        chk("pre_rst_level", 256'(level), 256'(7));
        do_reset();
        chk("rst_level", 256'(level), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_rec", 256'(out_rec), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_wen_err", 256'(wen_err), 256'(0));
        chk("rst_drop", 256'(drop_cnt), 256'(0));

        // Counters restart: event in the first cycle after release gets ts=0, seq=0.
        out_ready = 1'b1;
        rd_en = 1'b1; rd_addr = 5'd9; rd_wdata = 32'h0BADF00D; pc = 32'h900;
        cyc();
        idle_in();
        chk("restart_ts", 256'(out_rec.ts), 256'(0));
        chk("restart_seq", 256'(out_rec.seq), 256'(0));
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr1_tb_trace_collector.md
# scr1_tb_trace_collector

Testbench-side retire-trace collector for the SCR1 AHB/AXI top benches. It samples per-cycle commit probes from the pipeline: register writeback, LSU load and LSU store. Each active cycle is packed into one timestamped trace record and buffered in a FIFO. Records are drained over a valid/ready port by the trace file writer. The block sits between the hierarchical probe taps in the top testbench and the text trace writer downstream.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DROP_W`, 16: width of the saturating dropped-record counter.
- `clk`  in  1  bench clock.
- `rst_n`  in  1  synchronous active-low reset.
- `rd_en_i`  in  1  register writeback this cycle.
- `rd_addr_i`  in  5  destination register.
- `rd_wdata_i`  in  32  writeback data.
- `pc_i`  in  32  PC of the current EXU instruction.
- `mem_ren_i`  in  1  load request this cycle.
- `mem_wen_i`  in  3  store width, one-hot {word, hword, byte}; 0 means no store.
- `mem_addr_i`  in  32  LSU address.
- `mem_wdata_i`  in  32  store data.
- `out_valid_o`  out  1  head record available.
- `out_ready_i`  in  1  consumer accepts the head record.
- `out_rec_o`  out  $bits(type_scr1_trace_rec_s)  head record.
- `level_o`  out  $clog2(DEPTH)+1  occupancy.
- `overflow_o`  out  1  sticky: at least one record dropped.
- `wen_err_o`  out  1  sticky: multi-hot `mem_wen_i` seen.
- `drop_cnt_o`  out  DROP_W  dropped records, saturating.

## Operation
- Cycle counter `ts`: 32 bits, free-running, 0 in the first cycle after reset release, wraps at 2^32.
- Sequence counter `seq`: 32 bits, increments per accepted record, wraps.
- Event cycle: `rd_en_i | mem_ren_i | (|mem_wen_i)`. Exactly one record is formed per event cycle. Record fields:
  - ts, seq, pc
  - rd_v, rd_addr, rd_data
  - ld_v, st_v, size, mem_addr, mem_data
- Fields whose valid bit is 0 are forced to 0.
- Size encoding: byte=0, hword=1, word=2. Multi-hot `mem_wen_i` gives size=3 and sets st_v=1 and wen_err_o.
- Load and store both asserted in one cycle: both bits set, mem_data = store data.
- Push is accepted when `level < DEPTH`, or when the FIFO is full and a pop happens in the same cycle.
  - Otherwise the record is dropped: seq is not incremented, drop_cnt increments and saturates at all-ones, overflow_o sets.
- Pop happens when `out_valid_o & out_ready_i`.
- Show-ahead FIFO: out_rec_o is the head entry. It must not change while `out_valid_o & ~out_ready_i`.
- Empty FIFO with a simultaneous push and `out_ready_i=1`: there is no bypass, so the record appears the next cycle.
- Non-event cycles push nothing and only advance ts.

## Timing
- Reset (`rst_n`=0 at a `clk` edge) clears everything:
  - ts=0, seq=0, level_o=0, out_valid_o=0, out_rec_o=0, overflow_o=0, wen_err_o=0, drop_cnt_o=0.
- Reset asserted mid-operation discards all buffered records.
- Latency: an event at cycle N is visible on out_rec_o at N+1 if the FIFO was empty, with ts=N relative to reset release.
- level_o updates one cycle after the push/pop edge:
  - +1 for push only
  - −1 for pop only
  - unchanged for both or neither
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from the level, not from pointer compare.
- Sustained throughput is one record per cycle with `out_ready_i` held high.

## Configuration
- `SCR1_TRACE_MEM_EN` defined: load/store probes are active as described above.
- Not defined:
  - `mem_*` ports remain present but are ignored.
  - Only `rd_en_i` forms an event.
  - ld_v, st_v, size, mem_addr and mem_data are always 0.
  - wen_err_o stays 0.

## Structure
- Package `scr1_tb_trace_pkg` holds:
  - `type_scr1_trace_rec_s` (packed struct)
  - `type_scr1_trace_size_e` (SIZE_BYTE, SIZE_HWORD, SIZE_WORD, SIZE_ERR)
  - `SCR1_TRACE_TS_W` = 32
- Sub-module `scr1_tb_trace_fifo`: generic show-ahead synchronous FIFO, parameterised on width and depth, with push/pop/full/empty/level. The collector owns record formation, counters and drop accounting.

## Test plan
- Reset release, then `rd_en_i`=1, rd_addr=5, wdata=0xDEADBEEF, pc=0x200 at cycle 3, `out_ready_i`=1 → cycle 4: out_valid_o=1, rec {ts=3, seq=0, rd_v=1, rd_addr=5, rd_data=0xDEADBEEF, pc=0x200}, ld_v=st_v=0.
- Store with wen=3'b100, addr=0x1000, data=0x12345678 → st_v=1, size=2. With the macro off, no record and level_o stays 0.
- `out_ready_i`=0 and 20 consecutive rd events with DEPTH=16 → level_o=16, drop_cnt_o=4, overflow_o=1. Drained records have seq 0..15 in order, ts consecutive.
- FIFO full, one push and one pop in the same cycle → push accepted, level_o stays 16, drop_cnt_o unchanged.
- `out_ready_i` toggled every other cycle during a stream → out_rec_o stable while stalled, no loss or duplicate, seq strictly increasing.
- wen=3'b011 → size=3, wen_err_o=1 and sticky. Reset asserted with level 7 → all outputs 0 the next cycle.
